// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl: sequencer for a single-stage CIC decimator datapath.
// It drives the datapath clear, enable and decimation tick, and discards
// comb warm-up results. It saturates each comb result down to OUT_W and
// queues it in a small FIFO behind a valid/ready output.
module cic_dec_ctrl #(
    parameter int ACC_W      = 48,
    parameter int OUT_W      = 21,
    parameter int RATIO_W    = 8,
    parameter int WARMUP     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [RATIO_W-1:0]      cfg_ratio,
    input  logic [5:0]              cfg_shift,
    input  logic                    in_valid,
    output logic                    acc_clr,
    output logic                    comb_en,
    output logic                    dec_tick,
    input  logic                    comb_valid,
    input  logic signed [ACC_W-1:0] comb_data,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    ovf,
    output logic                    sat
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    // Saturation limits, sign-extended to the comb width for a signed compare.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARM  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [RATIO_W-1:0]   phase_q, phase_d;
    logic [RATIO_W-1:0]   ratio_q, ratio_d;
    logic [5:0]           shift_q, shift_d;
    logic [WCNT_W-1:0]    warm_cnt_q, warm_cnt_d;
    logic                 acc_clr_q, acc_clr_d;
    logic                 dec_tick_q, dec_tick_d;
    logic                 ovf_q, ovf_d;
    logic                 sat_q, sat_d;
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;

    logic [OUT_W-1:0]     fifo_mem [FIFO_DEPTH];

    logic                 active;
    logic [RATIO_W-1:0]   ratio_eff;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push_req;
    logic                 push;
    logic                 pop;
    logic signed [ACC_W-1:0] shifted;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [OUT_W-1:0]     slice_val;

    // Datapath-facing decode, FIFO status and the saturating slice.
    always_comb begin
        active     = (state_q == ST_WARM) || (state_q == ST_RUN);
        ratio_eff  = (cfg_ratio < RATIO_W'(2)) ? RATIO_W'(2) : cfg_ratio;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop        = !fifo_empty && out_ready;
        push_req   = (state_q == ST_RUN) && comb_valid;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push       = push_req && (!fifo_full || pop);
        shifted    = comb_data >>> shift_q;
        sat_hi     = (shifted > SAT_MAX);
        sat_lo     = (shifted < SAT_MIN);
        if (sat_hi) begin
            slice_val = SAT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            slice_val = SAT_MIN[OUT_W-1:0];
        end else begin
            slice_val = shifted[OUT_W-1:0];
        end
    end

    // Next-state logic: FSM, phase counter, sticky flags and FIFO pointers.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        ratio_d    = ratio_q;
        shift_d    = shift_q;
        warm_cnt_d = warm_cnt_q;
        acc_clr_d  = 1'b0;
        dec_tick_d = 1'b0;
        ovf_d      = ovf_q;
        sat_d      = sat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (push_req && (sat_hi || sat_lo)) begin
            sat_d = 1'b1;
        end

        // The tick is registered, so it lands one cycle after the last sample of a block.
        if (active && in_valid) begin
            if (phase_q == ratio_q - 1'b1) begin
                phase_d    = '0;
                dec_tick_d = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = (WARMUP == 0) ? ST_RUN : ST_WARM;
                    ratio_d    = ratio_eff;
                    shift_d    = cfg_shift;
                    phase_d    = '0;
                    warm_cnt_d = '0;
                    ovf_d      = 1'b0;
                    sat_d      = 1'b0;
                    acc_clr_d  = 1'b1;
                end
            end
            ST_WARM: begin
                // Stop wins over a warm-up count that completes in the same cycle.
                if (stop) begin
                    state_d = ST_FLUSH;
                end else if (comb_valid) begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                    if (warm_cnt_q == WCNT_W'(WARMUP - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Leave as soon as the last queued word is taken.
                if (wr_ptr_d == rd_ptr_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and status registers; reset aborts any conversion and empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            ratio_q    <= RATIO_W'(2);
            shift_q    <= '0;
            warm_cnt_q <= '0;
            acc_clr_q  <= 1'b0;
            dec_tick_q <= 1'b0;
            ovf_q      <= 1'b0;
            sat_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            ratio_q    <= ratio_d;
            shift_q    <= shift_d;
            warm_cnt_q <= warm_cnt_d;
            acc_clr_q  <= acc_clr_d;
            dec_tick_q <= dec_tick_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= slice_val;
        end
    end

    // Output decode; out_data reads as zero while the FIFO is empty.
    always_comb begin
        acc_clr   = acc_clr_q;
        dec_tick  = dec_tick_q;
        comb_en   = active;
        busy      = (state_q != ST_IDLE);
        out_valid = !fifo_empty;
        ovf       = ovf_q;
        sat       = sat_q;
        out_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
    end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: direct checks plus a scoreboard of
// expected FIFO words that is compared as the DUT hands words downstream.
module tb_cic_dec_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  cfg_ratio;
    logic [5:0]  cfg_shift;
    logic        in_valid;
    logic        acc_clr;
    logic        comb_en;
    logic        dec_tick;
    logic        comb_valid;
    logic signed [47:0] comb_data;
    logic [20:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        ovf;
    logic        sat;

    int n_vec = 0;
    int n_err = 0;
    logic [20:0] exp_q [$];

    cic_dec_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_ratio  (cfg_ratio),
        .cfg_shift  (cfg_shift),
        .in_valid   (in_valid),
        .acc_clr    (acc_clr),
        .comb_en    (comb_en),
        .dec_tick   (dec_tick),
        .comb_valid (comb_valid),
        .comb_data  (comb_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .ovf        (ovf),
        .sat        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one comb result for a cycle; kept words are queued as expected output.
    task automatic send_comb(input logic [47:0] d, input bit kept, input logic [20:0] e);
        comb_valid = 1'b1;
        comb_data  = d;
        if (kept) exp_q.push_back(e);
        step();
        comb_valid = 1'b0;
        comb_data  = '0;
    endtask

    task automatic do_start(input logic [7:0] ratio, input logic [5:0] shift, input string tag);
        cfg_ratio = ratio;
        cfg_shift = shift;
        start     = 1'b1;
        step();
        start     = 1'b0;
        #1;
        check({tag, "_acc_clr_hi"}, 64'(acc_clr), 64'd1);
        check({tag, "_busy"},       64'(busy),    64'd1);
        check({tag, "_comb_en"},    64'(comb_en), 64'd1);
        step();
        #1;
        check({tag, "_acc_clr_lo"}, 64'(acc_clr), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 100; c++) begin
            step();
            #1;
            if (!busy) break;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic do_stop(input string tag);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(tag);
    endtask

    // Period between two consecutive ticks; in_valid either held high or toggled.
    task automatic measure(input bit toggle, input int exp_period, input string tag);
        int first;
        int period;
        first  = -1;
        period = -1;
        for (int c = 0; c < 300; c++) begin
            step();
            if (toggle) in_valid = ~in_valid;
            else        in_valid = 1'b1;
            #1;
            if (dec_tick) begin
                if (first < 0) begin
                    first = c;
                end else begin
                    period = c - first;
                    break;
                end
            end
        end
        check(tag, 64'(period), 64'(exp_period));
        in_valid = 1'b1;
    endtask

    // Scoreboard: compare every word the DUT hands downstream.
    always begin : sb_mon
        logic [20:0] e;
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                $display("txn pop out_data=0x%06h expected=0x%06h", out_data, e);
                check("sb_data", 64'(out_data), 64'(e));
            end
        end
    end

    initial begin
        int ticks;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        cfg_ratio  = '0;
        cfg_shift  = '0;
        in_valid   = 1'b0;
        comb_valid = 1'b0;
        comb_data  = '0;
        out_ready  = 1'b1;
        #1;
        check("rst_outputs", {acc_clr, comb_en, dec_tick, out_valid, busy, ovf, sat, out_data}, 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);

        // M=32, continuous input, warm-up discard and first-word latency
        in_valid = 1'b1;
        do_start(8'd32, 6'd0, "m32");
        measure(1'b0, 32, "tick_m32");
        send_comb(48'd5, 1'b0, '0);
        #1 check("warm_drop1", 64'(out_valid), 64'd0);
        send_comb(48'd6, 1'b0, '0);
        #1 check("warm_drop2", 64'(out_valid), 64'd0);
        send_comb(48'd123, 1'b1, 21'd123);
        #1 check("first_word_lat", 64'(out_valid), 64'd1);
        do_stop("m32");

        // M=4 with gapped input, slicing and saturation
        do_start(8'd4, 6'd4, "m4");
        measure(1'b1, 8, "tick_m4_gap");
        send_comb(48'd1, 1'b0, '0);
        send_comb(48'd2, 1'b0, '0);
        send_comb(48'h0000_0010_0000, 1'b1, 21'h10000);
        #1 check("sat_clear", 64'(sat), 64'd0);
        send_comb(48'h0000_4000_0000, 1'b1, 21'h0FFFFF);
        #1 check("sat_pos", 64'(sat), 64'd1);
        send_comb(48'hFFFF_C000_0000, 1'b1, 21'h100000);
        do_stop("m4");

        // Ratios below 2 behave as 2
        do_start(8'd0, 6'd0, "m0");
        measure(1'b0, 2, "tick_m0");
        do_stop("m0");
        do_start(8'd1, 6'd0, "m1");
        measure(1'b0, 2, "tick_m1");
        do_stop("m1");

        // Fill, push+pop when full, overflow, ignored start while busy
        out_ready = 1'b0;
        do_start(8'd2, 6'd0, "ovf");
        send_comb(48'd9, 1'b0, '0);
        send_comb(48'd9, 1'b0, '0);
        send_comb(48'd1, 1'b1, 21'd1);
        send_comb(48'd2, 1'b1, 21'd2);
        send_comb(48'd3, 1'b1, 21'd3);
        send_comb(48'd4, 1'b1, 21'd4);
        #1;
        check("full_head", 64'(out_data), 64'd1);
        check("full_ovf0", 64'(ovf), 64'd0);
        out_ready = 1'b1;
        send_comb(48'h0000_4000_0000, 1'b1, 21'h0FFFFF);
        out_ready = 1'b0;
        #1;
        check("pushpop_no_ovf", 64'(ovf), 64'd0);
        check("pushpop_sat", 64'(sat), 64'd1);
        send_comb(48'd6, 1'b0, '0);
        #1;
        check("drop_ovf", 64'(ovf), 64'd1);
        check("drop_head", 64'(out_data), 64'd2);
        cfg_ratio = 8'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check("busy_start_acc_clr", 64'(acc_clr), 64'd0);
        check("busy_start_ovf", 64'(ovf), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Stop with three words queued: no ticks, busy until the last pop
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        ticks = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            #1;
            if (dec_tick) ticks++;
        end
        check("flush_no_tick", 64'(ticks), 64'd0);
        check("flush_busy0", 64'(busy), 64'd1);
        check("flush_comb_en", 64'(comb_en), 64'd0);
        out_ready = 1'b1;
        step();
        #1 check("flush_busy1", 64'(busy), 64'd1);
        step();
        #1 check("flush_busy2", 64'(busy), 64'd1);
        step();
        #1;
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_empty", 64'(out_valid), 64'd0);

        // Fresh start clears flags and loads the new configuration
        do_start(8'd3, 6'd2, "restart");
        check("restart_ovf", 64'(ovf), 64'd0);
        check("restart_sat", 64'(sat), 64'd0);
        measure(1'b0, 3, "tick_m3");
        send_comb(48'd1, 1'b0, '0);
        send_comb(48'd1, 1'b0, '0);
        send_comb(48'd400, 1'b1, 21'd100);
        step();

        // Reset in RUN with words queued
        out_ready = 1'b0;
        send_comb(48'd7, 1'b0, '0);
        send_comb(48'd8, 1'b0, '0);
        #1 check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {acc_clr, comb_en, dec_tick, out_valid, busy, ovf, sat, out_data}, 64'd0);
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        #1;
        check("rel_busy", 64'(busy), 64'd0);
        check("rel_valid", 64'(out_valid), 64'd0);
        step();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
